fix_div: RTL and testbench

//  Sequential signed fixed-point divider, Q(WIDTH-FRAC).(FRAC) format; inverse operation of the fixed-point add/mul datapath.

---
 rtl/fix_div_pkg.sv | 26 ++
 rtl/fix_div_if.sv | 25 ++
 rtl/fix_div_step.sv | 21 ++
 rtl/fix_div.sv | 119 +++++++++++
 tb/tb_fix_div.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/fix_div_pkg.sv
// Shared types and constants for the fixed-point divider.
// Provides default geometry, FSM states, saturation limits and sign helpers.
package fix_pkg;

    localparam int WIDTH = 32;
    localparam int FRAC  = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] fx_neg(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // |MIN_NEG| wraps to itself, which read as unsigned is the right magnitude.
    function automatic logic [WIDTH-1:0] fx_abs(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? fx_neg(x) : x;
    endfunction

endpackage

// File: rtl/fix_div_if.sv
// Operand/result handshake bundle for fix_div.
// master: drives in_valid/a/b/out_ready; slave: drives in_ready/out_valid/quot/flags.
interface fix_div_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quot;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, quot, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, quot, div_by_zero, overflow
    );
endinterface

// File: rtl/fix_div_step.sv
// One combinational restoring-division step.
// i_rem/i_bit/i_div in -> o_rem (next remainder), o_q (quotient bit).
module fix_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_div,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_q
);
    logic [WIDTH:0]   w_sh;
    logic [WIDTH-1:0] w_diff;

    // Remainder stays below the divisor, so it fits WIDTH bits;
    // only the shifted value needs the extra bit for the compare.
    assign w_sh   = {i_rem, i_bit};
    assign o_q    = (w_sh >= {1'b0, i_div});
    assign w_diff = w_sh[WIDTH-1:0] - i_div;
    assign o_rem  = o_q ? w_diff : w_sh[WIDTH-1:0];
endmodule

// File: rtl/fix_div.sv
// Sequential signed fixed-point divider: quot = (a << FRAC) / b, saturated.
// Ports: clk, rst (sync, active-high), bus (fix_div_if.slave handshake).
module fix_div
    import fix_pkg::*;
#(
    parameter int WIDTH = fix_pkg::WIDTH,
    parameter int FRAC  = fix_pkg::FRAC
) (
    input  logic      clk,
    input  logic      rst,
    fix_div_if.slave  bus
);
    localparam int N  = WIDTH + FRAC;
    localparam int CW = $clog2(N);

    localparam logic [N-1:0] LIM_POS = N'(MAX_POS);
    localparam logic [N-1:0] LIM_NEG = N'(MAX_POS) + 1'b1;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [N-1:0]     r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_bmag;
    logic             r_sign;
    logic             r_aneg;
    logic [WIDTH-1:0] r_quot;
    logic             r_dz;
    logic             r_ovf;
    logic             r_out_valid;

    logic [WIDTH-1:0] w_rem;
    logic             w_q;
    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;

    assign w_amag = fx_abs(bus.a);
    assign w_bmag = fx_abs(bus.b);

    fix_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem (r_rem),
        .i_bit (r_div[N-1]),
        .i_div (r_bmag),
        .o_rem (w_rem),
        .o_q   (w_q)
    );

    assign bus.in_ready    = (r_state == IDLE);
    assign bus.out_valid   = r_out_valid;
    assign bus.quot        = r_quot;
    assign bus.div_by_zero = r_dz;
    assign bus.overflow    = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_div       <= '0;
            r_rem       <= '0;
            r_bmag      <= '0;
            r_sign      <= 1'b0;
            r_aneg      <= 1'b0;
            r_quot      <= '0;
            r_dz        <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_sign  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_aneg  <= bus.a[WIDTH-1];
                        r_bmag  <= w_bmag;
                        // r_div shifts dividend bits out of the top and
                        // quotient bits in at the bottom.
                        r_div   <= N'(w_amag) << FRAC;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_ovf   <= 1'b0;
                        r_dz    <= (bus.b == '0);
                        r_state <= (bus.b == '0) ? DONE : CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_rem;
                    r_div <= {r_div[N-2:0], w_q};
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle applies sign and saturation.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        if (r_dz) begin
                            r_quot <= r_aneg ? MIN_NEG : MAX_POS;
                        end else if (!r_sign && (r_div > LIM_POS)) begin
                            r_quot <= MAX_POS;
                            r_ovf  <= 1'b1;
                        end else if (r_sign && (r_div > LIM_NEG)) begin
                            r_quot <= MIN_NEG;
                            r_ovf  <= 1'b1;
                        end else if (r_sign) begin
                            r_quot <= fx_neg(r_div[WIDTH-1:0]);
                        end else begin
                            r_quot <= r_div[WIDTH-1:0];
                        end
                    end else if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fix_div.sv
// Directed scoreboard bench for fix_div (WIDTH=32, FRAC=16).
// Expected results are queued on accept and popped when out_valid rises.
module tb_fix_div;
    import fix_pkg::*;

    typedef struct packed {
        logic [31:0] q;
        logic        dz;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    fix_div_if #(.WIDTH(32)) bus ();

    fix_div #(
        .WIDTH (32),
        .FRAC  (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    function automatic exp_t mk(input logic [31:0] q, input logic dz, input logic ovf);
        exp_t e;
        e.q   = q;
        e.dz  = dz;
        e.ovf = ovf;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input exp_t e);
        int n = 0;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("issue_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int lat, input int hold);
        int   n = 1;
        exp_t e;
        // issue() returns 1 ns after the accept edge: cycle 1 is the next edge.
        while (n <= 200) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) break;
            n++;
        end
        chk({tag, "_lat"}, n, lat);
        chk({tag, "_sb"}, 32'(sb.size()), 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : mk('x, 1'bx, 1'bx);
        chk({tag, "_quot"}, bus.quot, e.q);
        chk({tag, "_dz"}, {31'b0, bus.div_by_zero}, {31'b0, e.dz});
        chk({tag, "_ovf"}, {31'b0, bus.overflow}, {31'b0, e.ovf});
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.a        = 32'h0001_0000;
            bus.b        = 32'h0001_0000;
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, {31'b0, bus.out_valid}, 32'd1);
            chk({tag, "_hold_ready"}, {31'b0, bus.in_ready}, 32'd0);
            chk({tag, "_hold_quot"}, bus.quot, e.q);
            chk({tag, "_hold_flags"}, {30'b0, bus.div_by_zero, bus.overflow}, {30'b0, e.dz, e.ovf});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({tag, "_rel_valid"}, {31'b0, bus.out_valid}, 32'd0);
        chk({tag, "_rel_ready"}, {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_quot", bus.quot, 32'd0);
        chk("rst_flags", {30'b0, bus.div_by_zero, bus.overflow}, 32'd0);
        rst = 1'b0;

        issue(32'h0003_0000, 32'h0002_0000, mk(32'h0001_8000, 1'b0, 1'b0));
        collect("d3_2", 49, 0);
        issue(32'hFFF8_8000, 32'h0002_8000, mk(32'hFFFD_0000, 1'b0, 1'b0));
        collect("dm75_25", 49, 0);
        issue(32'h0001_0000, 32'h0003_0000, mk(32'h0000_5555, 1'b0, 1'b0));
        collect("d1_3", 49, 0);
        issue(32'hFFFF_0000, 32'h0003_0000, mk(32'hFFFF_AAAB, 1'b0, 1'b0));
        collect("dm1_3", 49, 0);
        issue(32'h0000_0000, 32'hFFFF_0000, mk(32'h0000_0000, 1'b0, 1'b0));
        collect("d0_m1", 49, 0);
        issue(32'h0005_0000, 32'h0000_0000, mk(32'h7FFF_FFFF, 1'b1, 1'b0));
        collect("dz_pos", 1, 0);
        issue(32'hFFFB_0000, 32'h0000_0000, mk(32'h8000_0000, 1'b1, 1'b0));
        collect("dz_neg", 1, 0);
        issue(32'h7FFF_0000, 32'h0000_0100, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        collect("ovf_pos", 49, 0);
        issue(32'h8000_0000, 32'h0001_0000, mk(32'h8000_0000, 1'b0, 1'b0));
        collect("min_neg", 49, 0);
        issue(32'h8000_0000, 32'hFFFF_0000, mk(32'h7FFF_FFFF, 1'b0, 1'b1));
        collect("ovf_neg1", 49, 0);

        issue(32'h0003_0000, 32'h0002_0000, mk(32'h0001_8000, 1'b0, 1'b0));
        collect("bp", 49, 10);

        issue(32'h0007_0000, 32'h0002_0000, mk(32'h0003_8000, 1'b0, 1'b0));
        void'(sb.pop_back());
        repeat (19) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("abort_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("abort_quot", bus.quot, 32'd0);
        seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen++;
        end
        chk("abort_no_result", seen, 32'd0);
        issue(32'h0003_0000, 32'h0002_0000, mk(32'h0001_8000, 1'b0, 1'b0));
        collect("post_abort", 49, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
